// File: rtl/yarvi_asm.sv
// yarvi_asm -- streaming RV32I instruction encoder.
//
// Takes a mnemonic code plus register/immediate fields and emits the encoded
// 32-bit instruction word tagged with the PC it occupies. The block keeps its
// own PC, so branch and JAL targets arrive as absolute addresses and are
// turned into PC-relative offsets here.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready = !out_valid | out_ready)
//   in_op               mnemonic code (0..40 legal, 41..63 illegal)
//   in_rd/rs1/rs2       register fields
//   in_imm              immediate / absolute target / full LUI-AUIPC value
//   load_pc(_value)     overwrite the PC (bits [1:0] forced to 0)
//   out_valid/out_ready output handshake
//   out_pc, out_insn    PC and encoded word (word forced to 0 on error)
//   out_err             0 ok, 1 immediate range, 2 misaligned target, 3 illegal op
module yarvi_asm #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   input  logic        load_pc,
   input  logic [31:0] load_pc_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_insn,
   output logic [1:0]  out_err
);

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   // funct3 for every op code that carries one
   function automatic logic [2:0] f3_of(input logic [5:0] op);
      logic [2:0] f;
      case (op)
         6'd4, 6'd10, 6'd15, 6'd18, 6'd27, 6'd28:        f = 3'd0;
         6'd5, 6'd11, 6'd16, 6'd24, 6'd29:               f = 3'd1;
         6'd12, 6'd17, 6'd19, 6'd30:                     f = 3'd2;
         6'd20, 6'd31:                                   f = 3'd3;
         6'd6, 6'd13, 6'd21, 6'd32:                      f = 3'd4;
         6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34:        f = 3'd5;
         6'd8, 6'd22, 6'd35:                             f = 3'd6;
         6'd9, 6'd23, 6'd36:                             f = 3'd7;
         default:                                        f = 3'd0;
      endcase
      return f;
   endfunction

   logic        r_valid;
   logic [31:0] r_out_pc;
   logic [31:0] r_insn;
   logic [1:0]  r_err;
   logic [31:0] r_pc;

   logic        w_accept;
   logic [31:0] w_load_pc;
   logic [31:0] w_pc_eff;
   logic [31:0] w_off;
   logic        w_i_ok;
   logic        w_sh_ok;
   logic        w_u_ok;
   logic        w_b_ok;
   logic        w_j_ok;
   logic [2:0]  w_f3;
   logic        w_alt;
   logic [31:0] w_insn;
   logic [1:0]  w_err;

   assign in_ready  = !r_valid | out_ready;
   assign w_accept  = in_valid & in_ready;
   assign w_load_pc = load_pc_value & 32'hFFFF_FFFC;
   // A same-cycle load_pc defines the PC of the word being accepted.
   assign w_pc_eff  = load_pc ? w_load_pc : r_pc;
   assign w_off     = in_imm - w_pc_eff;

   // Range checks: the upper bits must be a pure sign extension.
   assign w_i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign w_sh_ok = ~(|in_imm[31:5]);
   assign w_u_ok  = ~(|in_imm[11:0]);
   assign w_b_ok  = (&w_off[31:12]) | ~(|w_off[31:12]);
   assign w_j_ok  = (&w_off[31:20]) | ~(|w_off[31:20]);

   assign w_f3  = f3_of(in_op);
   // funct7 bit 30 distinguishes SUB / SRA / SRAI
   assign w_alt = (in_op == 6'd26) | (in_op == 6'd28) | (in_op == 6'd34);

   always_comb begin
      w_insn = 32'h0000_0000;
      w_err  = 2'd0;
      if (in_op <= 6'd1) begin
         if (!w_u_ok) w_err = 2'd1;
         else w_insn = {in_imm[31:12], in_rd, (in_op == 6'd0) ? OPC_LUI : OPC_AUIPC};
      end else if (in_op == 6'd2) begin
         if (w_off[0])     w_err = 2'd2;
         else if (!w_j_ok) w_err = 2'd1;
         else w_insn = {w_off[20], w_off[10:1], w_off[11], w_off[19:12], in_rd, OPC_JAL};
      end else if (in_op == 6'd3) begin
         if (!w_i_ok) w_err = 2'd1;
         else w_insn = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end else if (in_op <= 6'd9) begin
         if (w_off[0])     w_err = 2'd2;
         else if (!w_b_ok) w_err = 2'd1;
         else w_insn = {w_off[12], w_off[10:5], in_rs2, in_rs1, w_f3,
                        w_off[4:1], w_off[11], OPC_BR};
      end else if (in_op <= 6'd14) begin
         if (!w_i_ok) w_err = 2'd1;
         else w_insn = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_LOAD};
      end else if (in_op <= 6'd17) begin
         if (!w_i_ok) w_err = 2'd1;
         else w_insn = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], OPC_STORE};
      end else if (in_op <= 6'd23) begin
         if (!w_i_ok) w_err = 2'd1;
         else w_insn = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_OPIMM};
      end else if (in_op <= 6'd26) begin
         if (!w_sh_ok) w_err = 2'd1;
         else w_insn = {1'b0, w_alt, 5'b00000, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_OPIMM};
      end else if (in_op <= 6'd36) begin
         w_insn = {1'b0, w_alt, 5'b00000, in_rs2, in_rs1, w_f3, in_rd, OPC_OP};
      end else if (in_op == 6'd37) begin
         w_insn = 32'h0FF0_000F;
      end else if (in_op == 6'd38) begin
         w_insn = 32'h0000_0073;
      end else if (in_op == 6'd39) begin
         w_insn = 32'h0010_0073;
      end else if (in_op == 6'd40) begin
         w_insn = 32'h3020_0073;
      end else begin
         w_err = 2'd3;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_out_pc <= RESET_PC;
         r_insn   <= 32'h0000_0000;
         r_err    <= 2'd0;
         r_pc     <= RESET_PC;
      end else if (w_accept) begin
         r_valid  <= 1'b1;
         r_out_pc <= w_pc_eff;
         r_insn   <= w_insn;
         r_err    <= w_err;
         r_pc     <= w_pc_eff + 32'd4;
      end else begin
         if (out_ready) r_valid <= 1'b0;
         if (load_pc)   r_pc    <= w_load_pc;
      end
   end

   assign out_valid = r_valid;
   assign out_pc    = r_out_pc;
   assign out_insn  = r_insn;
   assign out_err   = r_err;

endmodule
